// File: rtl/cdc_fifo_pkg.sv
// Shared dual-clock FIFO definitions: default sizes and Gray/binary helpers.
// The helpers work on a 32-bit word; callers zero-extend narrower pointers
// in and size-cast the result back to their own width.
package cdc_fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;

  typedef logic [31:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b     = '0;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into this clock,
// with the binary equivalent of the synchronized value. SYNC_DEPTH >= 2.
module gray_ptr_sync
  import cdc_fifo_pkg::*;
#(
  parameter int WIDTH      = 5,
  parameter int SYNC_DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_gray,
  output logic [WIDTH-1:0] q_gray,
  output logic [WIDTH-1:0] q_bin
);

  // Stage 0 samples the asynchronous input; the last stage is the safe copy.
  logic [SYNC_DEPTH-1:0][WIDTH-1:0] sync_q;

  // Shift the pointer through the flop chain; async clear to pointer 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_DEPTH-2:0], d_gray};
  end

  assign q_gray = sync_q[SYNC_DEPTH-1];
  assign q_bin  = WIDTH'(gray2bin(ptr_word_t'(q_gray)));

endmodule

// File: rtl/cdc_fifo_read_ctrl.sv
// Read-side controller of the dual-clock FIFO: synchronizes the writer's
// Gray pointer, owns the read pointer / RAM address, and presents a
// first-word-fall-through output register with valid/ready handshake.
module cdc_fifo_read_ctrl
  import cdc_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int SYNC_DEPTH = 2,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   rd_count
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wq_gray;
  logic [PW-1:0] wq_bin;
  logic [PW-1:0] rd_ptr_bin;
  logic [PW-1:0] rd_ptr_next;
  logic          empty;
  logic          load;

  gray_ptr_sync #(
    .WIDTH      (PW),
    .SYNC_DEPTH (SYNC_DEPTH)
  ) u_wr_sync (
    .clock  (clock),
    .reset  (reset),
    .d_gray (wr_ptr_gray),
    .q_gray (wq_gray),
    .q_bin  (wq_bin)
  );

  // The extra MSB separates laps, so equal Gray pointers mean truly empty.
  assign empty = (wq_gray == rd_ptr_gray);

  // Refill the output register whenever it is empty or being drained now.
  assign load        = !empty && (!out_valid || out_ready);
  assign rd_ptr_next = rd_ptr_bin + PW'(load);

  // Read pointer; the Gray copy is built from the next binary value so the
  // exported pointer is a clean register output that moves on the load edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_bin  <= '0;
      rd_ptr_gray <= '0;
    end else begin
      rd_ptr_bin  <= rd_ptr_next;
      rd_ptr_gray <= PW'(bin2gray(ptr_word_t'(rd_ptr_next)));
    end
  end

  // FWFT head register: load a word, or drop valid once it was consumed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mem_rd_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Occupancy as seen here; lags the writer by the synchronizer latency.
  assign rd_count = wq_bin - rd_ptr_bin;
  assign rd_addr  = rd_ptr_bin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_cdc_fifo_read_ctrl.sv
// Directed bench for cdc_fifo_read_ctrl (ADDR_WIDTH=4, SYNC_DEPTH=2):
// table-driven single-word/backpressure vectors, then stream, wrap and
// mid-stream reset sequences against a small RAM model.
module tb_cdc_fifo_read_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] wr_ptr_gray = '0;
  logic [4:0] rd_ptr_gray;
  logic [3:0] rd_addr;
  logic [7:0] mem_rd_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] rd_count;

  logic [7:0] mem [16];
  assign mem_rd_data = mem[rd_addr];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clock = ~clock;

  cdc_fifo_read_ctrl #(
    .ADDR_WIDTH (4),
    .SYNC_DEPTH (2),
    .DATA_WIDTH (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .rd_addr     (rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .rd_count    (rd_count)
  );

  // The exported read pointer must never move more than one Gray bit per edge.
  assert property (@(posedge clock) disable iff (reset)
                   $countones(rd_ptr_gray ^ $past(rd_ptr_gray)) <= 1)
    else $error("FAIL gray_step assertion: rd_ptr_gray=%0h", rd_ptr_gray);

  typedef struct {
    logic [4:0] wr;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] eg;
    logic [4:0] ec;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [4:0] g5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] word_of(input int w);
    return 8'(w * 7 + 3);
  endfunction

  task automatic do_reset();
    reset       = 1'b1;
    wr_ptr_gray = '0;
    out_ready   = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int         wp;
    logic [7:0] exp_q [$];
    logic [4:0] prev_gray;
    int         guard;
    int         remaining;

    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
    mem[0] = 8'hA5;

    // {wr_ptr_gray, out_ready} -> {out_valid, out_data, rd_ptr_gray, rd_count}
    vecs[0]  = '{5'd1, 1'b0, 1'b0, 8'h00, 5'd0, 5'd0};
    vecs[1]  = '{5'd1, 1'b0, 1'b0, 8'h00, 5'd0, 5'd1};
    vecs[2]  = '{5'd1, 1'b0, 1'b1, 8'hA5, 5'd1, 5'd0};
    vecs[3]  = '{5'd1, 1'b0, 1'b1, 8'hA5, 5'd1, 5'd0};
    vecs[4]  = '{5'd7, 1'b1, 1'b0, 8'hA5, 5'd1, 5'd0};
    vecs[5]  = '{5'd7, 1'b0, 1'b0, 8'hA5, 5'd1, 5'd4};
    vecs[6]  = '{5'd7, 1'b0, 1'b1, 8'h11, 5'd3, 5'd3};
    vecs[7]  = '{5'd7, 1'b0, 1'b1, 8'h11, 5'd3, 5'd3};
    vecs[8]  = '{5'd7, 1'b1, 1'b1, 8'h12, 5'd2, 5'd2};
    vecs[9]  = '{5'd7, 1'b0, 1'b1, 8'h12, 5'd2, 5'd2};
    vecs[10] = '{5'd7, 1'b0, 1'b1, 8'h12, 5'd2, 5'd2};
    vecs[11] = '{5'd7, 1'b1, 1'b1, 8'h13, 5'd6, 5'd1};
    vecs[12] = '{5'd7, 1'b0, 1'b1, 8'h13, 5'd6, 5'd1};
    vecs[13] = '{5'd7, 1'b0, 1'b1, 8'h13, 5'd6, 5'd1};
    vecs[14] = '{5'd7, 1'b1, 1'b1, 8'h14, 5'd7, 5'd0};
    vecs[15] = '{5'd7, 1'b0, 1'b1, 8'h14, 5'd7, 5'd0};
    vecs[16] = '{5'd7, 1'b1, 1'b0, 8'h14, 5'd7, 5'd0};

    // ---- reset with a random writer pointer present ----
    wr_ptr_gray = 5'($urandom_range(1, 31));
    @(posedge clock); #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_gray",  32'(rd_ptr_gray), 0);
    check("rst_count", 32'(rd_count), 0);
    check("rst_addr",  32'(rd_addr), 0);
    check("rst_data",  32'(out_data), 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check("rel_valid", 32'(out_valid), 0);
    check("rel_gray",  32'(rd_ptr_gray), 0);
    check("rel_count", 32'(rd_count), 0);

    // ---- single word then backpressure, table driven ----
    do_reset();
    for (int i = 0; i < 17; i++) begin
      wr_ptr_gray = vecs[i].wr;
      out_ready   = vecs[i].rdy;
      @(posedge clock); #1;
      check($sformatf("vec%0d_valid", i), 32'(out_valid),   32'(vecs[i].ev));
      check($sformatf("vec%0d_data",  i), 32'(out_data),    32'(vecs[i].ed));
      check($sformatf("vec%0d_gray",  i), 32'(rd_ptr_gray), 32'(vecs[i].eg));
      check($sformatf("vec%0d_count", i), 32'(rd_count),    32'(vecs[i].ec));
    end

    // ---- full-depth stream with out_ready held high ----
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    out_ready   = 1'b1;
    wr_ptr_gray = 5'h18;
    @(posedge clock); #1;
    check("strm_lat1_count", 32'(rd_count), 0);
    @(posedge clock); #1;
    check("strm_lat2_count", 32'(rd_count), 16);
    check("strm_lat2_valid", 32'(out_valid), 0);
    for (int k = 0; k < 16; k++) begin
      @(posedge clock); #1;
      check($sformatf("strm%0d_valid", k), 32'(out_valid), 1);
      check($sformatf("strm%0d_data",  k), 32'(out_data),  32'(k));
      check($sformatf("strm%0d_count", k), 32'(rd_count),  32'(15 - k));
    end
    @(posedge clock); #1;
    check("strm_end_valid", 32'(out_valid), 0);
    check("strm_end_gray",  32'(rd_ptr_gray), 32'h18);
    check("strm_end_count", 32'(rd_count), 0);

    // ---- 40 words through the pointer wrap, drained in chunks of 10 ----
    do_reset();
    wp        = 0;
    prev_gray = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      remaining = 10;
      guard     = 0;
      while ((remaining > 0 || exp_q.size() > 0) && guard < 100) begin
        if (remaining > 0) begin
          mem[wp % 16] = word_of(wp);
          exp_q.push_back(word_of(wp));
          wp++;
          wr_ptr_gray = g5(5'(wp));
          remaining--;
        end
        @(posedge clock); #1;
        guard++;
        check("wrap_gray_step", 32'($countones(rd_ptr_gray ^ prev_gray) <= 1), 1);
        prev_gray = rd_ptr_gray;
        if (out_valid) begin
          if (exp_q.size() == 0) check("wrap_extra_word", 32'(out_data), 32'hFFFF_FFFF);
          else                   check("wrap_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      check($sformatf("wrap%0d_timeout", c), 32'(guard < 100), 1);
      repeat (3) @(posedge clock);
      #1;
      check($sformatf("wrap%0d_valid", c), 32'(out_valid), 0);
      check($sformatf("wrap%0d_count", c), 32'(rd_count), 0);
      check($sformatf("wrap%0d_empty", c), 32'(rd_ptr_gray), 32'(g5(5'(wp))));
      prev_gray = rd_ptr_gray;
    end
    check("wrap_final_gray", 32'(rd_ptr_gray), 32'h0C);

    // ---- reset while words are pending and the head is valid ----
    do_reset();
    out_ready = 1'b0;
    wp        = 0;
    for (int i = 0; i < 5; i++) begin
      mem[wp % 16] = word_of(wp);
      wp++;
      wr_ptr_gray = g5(5'(wp));
      @(posedge clock);
    end
    #1;
    guard = 0;
    while (!out_valid && guard < 10) begin
      @(posedge clock); #1;
      guard++;
    end
    check("mid_pre_valid", 32'(out_valid), 1);
    reset = 1'b1;
    #1;
    check("mid_valid", 32'(out_valid), 0);
    check("mid_data",  32'(out_data), 0);
    check("mid_gray",  32'(rd_ptr_gray), 0);
    check("mid_count", 32'(rd_count), 0);
    check("mid_addr",  32'(rd_addr), 0);
    wr_ptr_gray = '0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check($sformatf("post_rst%0d_valid", i), 32'(out_valid), 0);
      check($sformatf("post_rst%0d_count", i), 32'(rd_count), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/cdc_fifo_read_ctrl.md
# cdc_fifo_read_ctrl

Read-domain controller of the dual-clock FIFO. It takes the write domain's Gray-coded write pointer and synchronizes it into the read clock. It also owns the read pointer and drives the RAM read address. It presents a first-word-fall-through valid/ready output and exports its own Gray read pointer back to the write domain.

## Interface
- ADDR_WIDTH, 4, RAM address bits; FIFO depth = 2**ADDR_WIDTH
- SYNC_DEPTH, 2, flop stages on the incoming write pointer (min 2)
- DATA_WIDTH, 8, word width
- clock  input  1  read-domain clock
- reset  input  1  asynchronous, active-high
- wr_ptr_gray  input  ADDR_WIDTH+1  write pointer, Gray, write-clock domain (asynchronous here)
- rd_ptr_gray  output  ADDR_WIDTH+1  read pointer, Gray, registered, to write domain
- rd_addr  output  ADDR_WIDTH  RAM read address = rd_ptr_bin[ADDR_WIDTH-1:0]
- mem_rd_data  input  DATA_WIDTH  RAM word at rd_addr, combinational read
- out_data  output  DATA_WIDTH  head word
- out_valid  output  1  out_data holds a word
- out_ready  input  1  consumer accepts out_data this cycle
- rd_count  output  ADDR_WIDTH+1  words in RAM not yet loaded into the output register

## Operation
- Sync: wr_ptr_gray passes through a SYNC_DEPTH-stage flop chain to give wq_gray; wq_bin = Gray-to-binary(wq_gray).
- Read pointer: rd_ptr_bin is ADDR_WIDTH+1 bits and wraps modulo 2**(ADDR_WIDTH+1). rd_ptr_gray is registered as bin ^ (bin >> 1), computed from the next rd_ptr_bin so that it is glitch-free and updates on the same edge.
- empty = (wq_gray == rd_ptr_gray), combinational in the read domain.
- load = !empty && (!out_valid || out_ready).
- On load: out_data <= mem_rd_data, out_valid <= 1, rd_ptr_bin += 1.
- Else if out_valid && out_ready: out_valid <= 0. out_data holds its value.
- Otherwise all state holds.
- rd_count = (wq_bin - rd_ptr_bin) mod 2**(ADDR_WIDTH+1). Range 0..2**ADDR_WIDTH. It is conservative, because it lags the writer by the sync latency.
- Underflow is impossible by construction. The read pointer never passes wq.
- out_data is unchanged while out_valid && !out_ready.

## Timing
- Reset values: rd_ptr_bin = 0, rd_ptr_gray = 0, all sync flops = 0, out_valid = 0, out_data = 0, rd_count = 0, rd_addr = 0.
- Reset mid-operation clears all state immediately (asynchronous). Words held in the RAM are discarded logically. The write domain must be reset in the same reset window.
- Write-to-read latency: wr_ptr_gray changes and is held stable. wq_gray updates after SYNC_DEPTH read edges. out_valid rises on the next edge (SYNC_DEPTH+1 edges total).
- Throughput: one word per cycle while !empty and out_ready is held high. In that state a pop and a load occur on the same edge, with no bubble.
- rd_ptr_gray changes exactly one bit per increment, on the load edge.
- Full wrap: after 2**(ADDR_WIDTH+1) loads, rd_ptr returns to 0. empty/rd_count stay correct because the MSB distinguishes the laps.
- A simultaneous wq update and load in the same cycle is legal. The comparison uses pre-edge values.

## Structure
- Shared package cdc_fifo_pkg holds:
  - the default ADDR_WIDTH and DATA_WIDTH constants;
  - the function bin2gray;
  - the function gray2bin.
  The write-side controller uses the same package.
- One natural sub-module: gray_ptr_sync, the SYNC_DEPTH flop chain with async reset to 0 plus a gray2bin output.
- The FWFT output register and pointer logic stay in cdc_fifo_read_ctrl.

## Test plan
All scenarios use ADDR_WIDTH=4, SYNC_DEPTH=2.
- Reset: assert reset with random wr_ptr_gray -> out_valid=0, rd_ptr_gray=0, rd_count=0 during and 1 cycle after release.
- Single word: wr_ptr_gray 0->1 with mem_rd_data=0xA5, out_ready=0 -> out_valid rises 3 edges later with out_data=0xA5. rd_ptr_gray becomes 1 on that edge. The output holds while out_ready=0.
- Stream: wr_ptr_gray stepped to gray(16) with RAM preloaded 0..15, out_ready=1 -> 16 consecutive words 0..15 on consecutive cycles. rd_count goes 16→0. rd_ptr_gray ends at gray(16)=0x18.
- Backpressure: 4 words available, out_ready toggles 1,0,0,1,... -> no word lost or duplicated. out_data is stable while stalled.
- Wrap: 40 words in total through the pointer wrap at 32 -> data order is preserved. After every drain, empty=1 and rd_count=0. rd_ptr_gray changes only one bit per step (checked by assertion).
- Reset mid-stream: assert reset with 5 words pending and out_valid=1 -> all outputs return to their reset values in the same cycle. After reset, with wr_ptr_gray=0, no spurious out_valid.
